// File: rtl/sram_ext_pkg.sv
// Shared types and helpers for the parametrised 1W1R masked SRAM macro.
// Holds the init-sequencer state encoding and the read-during-write policy constants.
package sram_ext_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int nlanes(input int dataW, input int maskGran);
        return dataW / maskGran;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset init sequencer: sweeps every word address once and writes zero.
// Drives the init write port and init_busy until the sweep completes.
module sram_init_seq
    import sram_ext_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int ADDR_W        = 6,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              initWe_o,
    output logic [ADDR_W-1:0] initAddr_o,
    output logic              initBusy_o
);

    localparam state_e            RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The last sweep write leaves the counter parked; it is only reused after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        initWe_o   = (state_q == ST_INIT);
        initAddr_o = cnt_q;
        initBusy_o = (state_q == ST_INIT);
    end

endmodule

// File: rtl/sram_1r1w_masked_ext.sv
// Single-clock 1W1R behavioural SRAM with per-lane write mask, 1/2-cycle read latency,
// selectable read-during-write policy and an optional zeroing sweep after reset.
module sram_1r1w_masked_ext
    import sram_ext_pkg::*;
#(
    parameter  int DATA_W        = 160,
    parameter  int DEPTH         = 64,
    parameter  int MASK_GRAN     = 8,
    parameter  int READ_LATENCY  = 1,
    parameter  int RDW_NEW       = 0,
    parameter  int INIT_ON_RESET = 1,
    localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NLANES        = nlanes(DATA_W, MASK_GRAN)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [DATA_W-1:0] W0_data,
    input  logic [NLANES-1:0] W0_mask,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [DATA_W-1:0] R0_data,
    output logic              R0_valid,
    output logic              init_busy
);

    if (DATA_W % MASK_GRAN != 0) begin : gBadGran
        $error("DATA_W must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
        $error("READ_LATENCY must be 1 or 2");
    end

    logic              initWe;
    logic [ADDR_W-1:0] initAddr;
    logic              initBusy;

    sram_init_seq #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) uInitSeq (
        .clock     (clock),
        .reset_n   (reset_n),
        .initWe_o  (initWe),
        .initAddr_o(initAddr),
        .initBusy_o(initBusy)
    );

    assign init_busy = initBusy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrInRange, rdInRange;
    logic              wrAccept, rdAccept;
    logic [DATA_W-1:0] wrOld, wrMerged, rdWord;

    // Out-of-range addresses never touch the array: writes drop, reads see zero.
    always_comb begin
        wrInRange = (int'(W0_addr) < DEPTH);
        rdInRange = (int'(R0_addr) < DEPTH);
        wrAccept  = !initBusy && W0_en && wrInRange;
        rdAccept  = !initBusy && R0_en;
        wrOld     = wrInRange ? mem[W0_addr] : '0;
        wrMerged  = wrOld;
        for (int i = 0; i < NLANES; i++) begin
            if (W0_mask[i]) begin
                wrMerged[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
            end
        end
        rdWord = rdInRange ? mem[R0_addr] : '0;
        if (RDW_NEW == sram_ext_pkg::RDW_NEW && wrAccept && W0_addr == R0_addr) begin
            rdWord = wrMerged;
        end
    end

    always_ff @(posedge clock) begin
        if (initWe) begin
            mem[initAddr] <= '0;
        end else if (wrAccept) begin
            mem[W0_addr] <= wrMerged;
        end
    end

    logic              s1Valid_q;
    logic [DATA_W-1:0] s1Data_q;

    // Data registers only load on a completed read so the output holds its last value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
        end else begin
            s1Valid_q <= rdAccept;
            if (rdAccept) begin
                s1Data_q <= rdWord;
            end
        end
    end

    if (READ_LATENCY == 2) begin : gLat2
        logic              s2Valid_q;
        logic [DATA_W-1:0] s2Data_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2Valid_q <= 1'b0;
                s2Data_q  <= '0;
            end else begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Data_q <= s1Data_q;
                end
            end
        end

        assign R0_valid = s2Valid_q;
        assign R0_data  = s2Data_q;
    end else begin : gLat1
        assign R0_valid = s1Valid_q;
        assign R0_data  = s1Data_q;
    end

endmodule

// File: tb/tb_sram_1r1w_masked_ext.sv
// Directed bench for sram_1r1w_masked_ext: three instances cover latency 1 / old-data RDW,
// latency 2 / new-data RDW, and a non-power-of-two depth of 48.
module tb_sram_1r1w_masked_ext;

    localparam int DW = 160;
    localparam int NL = 20;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    logic [5:0]    aWAddr, aRAddr, bWAddr, bRAddr, cWAddr, cRAddr;
    logic          aWEn, aREn, bWEn, bREn, cWEn, cREn;
    logic [DW-1:0] aWData, bWData, cWData, aRData, bRData, cRData;
    logic [NL-1:0] aWMask, bWMask, cWMask;
    logic          aRValid, bRValid, cRValid, aBusy, bBusy, cBusy;

    int errors = 0;
    int checks = 0;

    sram_1r1w_masked_ext #(.DATA_W(DW), .DEPTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                           .RDW_NEW(0), .INIT_ON_RESET(1)) uDutA (
        .clock(clock), .reset_n(reset_n),
        .W0_addr(aWAddr), .W0_en(aWEn), .W0_data(aWData), .W0_mask(aWMask),
        .R0_addr(aRAddr), .R0_en(aREn), .R0_data(aRData), .R0_valid(aRValid),
        .init_busy(aBusy)
    );

    sram_1r1w_masked_ext #(.DATA_W(DW), .DEPTH(64), .MASK_GRAN(8), .READ_LATENCY(2),
                           .RDW_NEW(1), .INIT_ON_RESET(1)) uDutB (
        .clock(clock), .reset_n(reset_n),
        .W0_addr(bWAddr), .W0_en(bWEn), .W0_data(bWData), .W0_mask(bWMask),
        .R0_addr(bRAddr), .R0_en(bREn), .R0_data(bRData), .R0_valid(bRValid),
        .init_busy(bBusy)
    );

    sram_1r1w_masked_ext #(.DATA_W(DW), .DEPTH(48), .MASK_GRAN(8), .READ_LATENCY(1),
                           .RDW_NEW(0), .INIT_ON_RESET(1)) uDutC (
        .clock(clock), .reset_n(reset_n),
        .W0_addr(cWAddr), .W0_en(cWEn), .W0_data(cWData), .W0_mask(cWMask),
        .R0_addr(cRAddr), .R0_en(cREn), .R0_data(cRData), .R0_valid(cRValid),
        .init_busy(cBusy)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        aWAddr = '0; aRAddr = '0; aWEn = 0; aREn = 0; aWData = '0; aWMask = '0;
        bWAddr = '0; bRAddr = '0; bWEn = 0; bREn = 0; bWData = '0; bWMask = '0;
        cWAddr = '0; cRAddr = '0; cWEn = 0; cREn = 0; cWData = '0; cWMask = '0;
    endtask

    task automatic writeA(input logic [5:0] addr, input logic [DW-1:0] data, input logic [NL-1:0] mask);
        aWAddr = addr; aWData = data; aWMask = mask; aWEn = 1;
        tick();
        aWEn = 0;
    endtask

    task automatic writeB(input logic [5:0] addr, input logic [DW-1:0] data, input logic [NL-1:0] mask);
        bWAddr = addr; bWData = data; bWMask = mask; bWEn = 1;
        tick();
        bWEn = 0;
    endtask

    task automatic writeC(input logic [5:0] addr, input logic [DW-1:0] data, input logic [NL-1:0] mask);
        cWAddr = addr; cWData = data; cWMask = mask; cWEn = 1;
        tick();
        cWEn = 0;
    endtask

    task automatic readA(input logic [5:0] addr, input logic [DW-1:0] expData, input string name);
        aRAddr = addr; aREn = 1;
        tick();
        aREn = 0;
        checks++;
        if (aRValid !== 1'b1 || aRData !== expData) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%0b data=%h, expected valid=1 data=%h", name, aRValid, aRData, expData);
        end
    endtask

    task automatic readC(input logic [5:0] addr, input logic [DW-1:0] expData, input string name);
        cRAddr = addr; cREn = 1;
        tick();
        cREn = 0;
        checks++;
        if (cRValid !== 1'b1 || cRData !== expData) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%0b data=%h, expected valid=1 data=%h", name, cRValid, cRData, expData);
        end
    endtask

    // Back-to-back reads of every address of instance A, each expected to be zero.
    task automatic sweepZeroA(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            aRAddr = 6'(i); aREn = 1;
            tick();
            if (aRValid !== 1'b1 || aRData !== '0) begin
                bad++;
                $display("[TB] FAIL %s: addr %0d got valid=%0b data=%h, expected valid=1 data=0", name, i, aRValid, aRData);
            end
        end
        aREn = 0;
        checks++;
        if (bad != 0) errors++;
    endtask

    // Counts cycles with init_busy high on A; a read held during the sweep must never complete.
    task automatic countBusyA(input string name);
        int cnt = 0;
        int badValid = 0;
        while (aBusy === 1'b1 && cnt < 200) begin
            if (aRValid !== 1'b0) badValid++;
            cnt++;
            tick();
        end
        aWEn = 0; aREn = 0;
        checks++;
        if (cnt != 64) begin
            errors++;
            $display("[TB] FAIL %s_busy_cycles: got %0d, expected 64", name, cnt);
        end
        checks++;
        if (badValid != 0 || aRValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_no_valid: got %0d valid cycles (now %0b), expected 0", name, badValid, aRValid);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        clearInputs();
        repeat (3) tick();
        checks++;
        if (aRValid !== 1'b0 || aRData !== '0 || aBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%0b data=%h busy=%0b, expected 0/0/1", aRValid, aRData, aBusy);
        end
        reset_n = 1;
        countBusyA("reset");
        sweepZeroA("reset_zero");
    endtask

    task automatic test_mask();
        logic [DW-1:0] exp = {{152{1'b1}}, 8'h00};
        writeA(6'd5, '1, '1);
        writeA(6'd5, '0, 20'h00001);
        readA(6'd5, exp, "mask_lane0");
        writeA(6'd5, '0, '0);
        readA(6'd5, exp, "mask_zero_noop");
    endtask

    task automatic test_latency2();
        logic [DW-1:0] d0 = {5{32'h11111111}};
        logic [DW-1:0] d1 = {5{32'h22222222}};
        logic [DW-1:0] d2 = {5{32'h33333333}};
        writeB(6'd0, d0, '1);
        writeB(6'd1, d1, '1);
        writeB(6'd2, d2, '1);
        bRAddr = 6'd0; bREn = 1;
        tick();
        checks++;
        if (bRValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat2_early: got valid=%0b, expected 0", bRValid);
        end
        bRAddr = 6'd1;
        tick();
        checks++;
        if (bRValid !== 1'b1 || bRData !== d0) begin
            errors++;
            $display("[TB] FAIL lat2_addr0: got valid=%0b data=%h, expected 1 %h", bRValid, bRData, d0);
        end
        bRAddr = 6'd2;
        tick();
        checks++;
        if (bRValid !== 1'b1 || bRData !== d1) begin
            errors++;
            $display("[TB] FAIL lat2_addr1: got valid=%0b data=%h, expected 1 %h", bRValid, bRData, d1);
        end
        bREn = 0;
        tick();
        checks++;
        if (bRValid !== 1'b1 || bRData !== d2) begin
            errors++;
            $display("[TB] FAIL lat2_addr2: got valid=%0b data=%h, expected 1 %h", bRValid, bRData, d2);
        end
        tick();
        checks++;
        if (bRValid !== 1'b0 || bRData !== d2) begin
            errors++;
            $display("[TB] FAIL lat2_hold: got valid=%0b data=%h, expected 0 %h", bRValid, bRData, d2);
        end
    endtask

    task automatic test_rdw();
        logic [DW-1:0] a5  = {20{8'hA5}};
        logic [DW-1:0] top = {8'hFF, {19{8'hA5}}};
        aWAddr = 6'd9; aWData = a5; aWMask = '1; aWEn = 1;
        aRAddr = 6'd9; aREn = 1;
        tick();
        aWEn = 0; aREn = 0;
        checks++;
        if (aRValid !== 1'b1 || aRData !== '0) begin
            errors++;
            $display("[TB] FAIL rdw_old: got valid=%0b data=%h, expected 1 0", aRValid, aRData);
        end
        readA(6'd9, a5, "rdw_write_then_read");

        bWAddr = 6'd9; bWData = a5; bWMask = '1; bWEn = 1;
        bRAddr = 6'd9; bREn = 1;
        tick();
        bWData = '1; bWMask = 20'h80000;
        tick();
        bWEn = 0; bREn = 0;
        checks++;
        if (bRValid !== 1'b1 || bRData !== a5) begin
            errors++;
            $display("[TB] FAIL rdw_new_full: got valid=%0b data=%h, expected 1 %h", bRValid, bRData, a5);
        end
        tick();
        checks++;
        if (bRValid !== 1'b1 || bRData !== top) begin
            errors++;
            $display("[TB] FAIL rdw_new_merge: got valid=%0b data=%h, expected 1 %h", bRValid, bRData, top);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] pat = {10{16'hC3E1}};
        writeC(6'd50, '1, '1);
        readC(6'd50, '0, "oob_read_50");
        readC(6'd2, '0, "oob_alias_2");
        readC(6'd18, '0, "oob_alias_18");
        writeC(6'd47, pat, '1);
        readC(6'd47, pat, "oob_inrange_47");
    endtask

    task automatic test_reset_midsweep();
        reset_n = 0;
        tick();
        reset_n = 1;
        aWAddr = 6'd5; aWData = '1; aWMask = '1; aWEn = 1;
        aRAddr = 6'd5; aREn = 1;
        begin
            int badValid = 0;
            for (int i = 0; i < 30; i++) begin
                if (aRValid !== 1'b0) badValid++;
                tick();
            end
            checks++;
            if (badValid != 0) begin
                errors++;
                $display("[TB] FAIL midsweep_pre_valid: got %0d valid cycles, expected 0", badValid);
            end
        end
        reset_n = 0;
        #1;
        checks++;
        if (aRValid !== 1'b0 || aRData !== '0 || aBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midsweep_reset: got valid=%0b data=%h busy=%0b, expected 0/0/1", aRValid, aRData, aBusy);
        end
        tick();
        tick();
        reset_n = 1;
        countBusyA("midsweep");
        sweepZeroA("midsweep_zero");
    endtask

    initial begin
        $display("[TB] starting sram_1r1w_masked_ext bench");
        test_reset();
        test_mask();
        test_latency2();
        test_rdw();
        test_out_of_range();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
